// File: rtl/serial_nibble_compare_ctrl.sv
// Serial MSB-first magnitude compare of two W-bit operands, one nibble per
// cycle, using an external combinational 4-bit comparator.
module serial_nibble_compare_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [3:0]           nib_a,
    output logic [3:0]           nib_b,
    input  logic                 cmp_eq,
    input  logic                 cmp_agb,
    input  logic                 cmp_alb,
    output logic                 busy,
    output logic                 done,
    output logic                 eq,
    output logic                 agb,
    output logic                 alb
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [IW-1:0]   r_idx;
    logic            r_eq;
    logic            r_agb;
    logic            r_alb;

    logic            w_load;
    logic            w_dec;
    logic            w_set_eq;
    logic            w_set_agb;
    logic            w_set_alb;
    logic [IW+1:0]   w_base;

    // cmp_eq is implied by neither agb nor alb, so it never steers the FSM
    logic            w_unused;
    assign w_unused = cmp_eq;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_set_eq    = 1'b0;
        w_set_agb   = 1'b0;
        w_set_alb   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CMP;
                end
            end
            CMP: begin
                if (cmp_agb) begin
                    w_set_agb   = 1'b1;
                    w_state_nxt = FIN;
                end else if (cmp_alb) begin
                    w_set_alb   = 1'b1;
                    w_state_nxt = FIN;
                end else if (r_idx == '0) begin
                    w_set_eq    = 1'b1;
                    w_state_nxt = FIN;
                end else begin
                    w_dec       = 1'b1;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_eq    <= 1'b0;
            r_agb   <= 1'b0;
            r_alb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_a   <= a;
                r_b   <= b;
                r_idx <= LAST;
                r_eq  <= 1'b0;
                r_agb <= 1'b0;
                r_alb <= 1'b0;
            end
            if (w_dec) begin
                r_idx <= r_idx - IW'(1);
            end
            if (w_set_eq) begin
                r_eq <= 1'b1;
            end
            if (w_set_agb) begin
                r_agb <= 1'b1;
            end
            if (w_set_alb) begin
                r_alb <= 1'b1;
            end
        end
    end

    assign w_base = {r_idx, 2'b00};

    always_comb begin
        nib_a = 4'b0000;
        nib_b = 4'b0000;
        if (r_state == CMP) begin
            nib_a = r_a[w_base +: 4];
            nib_b = r_b[w_base +: 4];
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == FIN);
    assign eq   = r_eq;
    assign agb  = r_agb;
    assign alb  = r_alb;

endmodule

// File: doc/serial_nibble_compare_ctrl.md
SERIAL_NIBBLE_COMPARE_CTRL -- requirements
Module: serial_nibble_compare_ctrl

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES, legal range 2..8.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: start  input  1  request to compare a against b; single-cycle pulse or level.
REQ-005 SHALL have port: a  input  W  operand A, unsigned; sampled only when start is accepted.
REQ-006 SHALL have port: b  input  W  operand B, unsigned; sampled only when start is accepted.
REQ-007 SHALL have port: nib_a  output  4  nibble of latched A, driven to the external 4-bit comparator.
REQ-008 SHALL have port: nib_b  output  4  nibble of latched B, driven to the external 4-bit comparator.
REQ-009 SHALL have port: cmp_eq  input  1  comparator result, nib_a == nib_b (combinational, same cycle).
REQ-010 SHALL have port: cmp_agb  input  1  comparator result, nib_a > nib_b.
REQ-011 SHALL have port: cmp_alb  input  1  comparator result, nib_a < nib_b.
REQ-012 SHALL have port: busy  output  1  high while a comparison is in progress or completing.
REQ-013 SHALL have port: done  output  1  one-cycle pulse when result outputs become valid.
REQ-014 SHALL have port: eq  output  1  registered result, A == B.
REQ-015 SHALL have port: agb  output  1  registered result, A > B.
REQ-016 SHALL have port: alb  output  1  registered result, A < B.

Function
REQ-017 SHALL implement FSM with states IDLE, CMP, FIN; busy = (state != IDLE).
REQ-018 In IDLE with start=1: latch a, b into a_reg, b_reg; set nibble index idx = NIBBLES-1; clear eq/agb/alb; go to CMP.
REQ-019 start SHALL be ignored in CMP and FIN; a and b changes while busy SHALL have no effect.
REQ-020 nib_a/nib_b SHALL equal a_reg/b_reg bits [4*idx+3 : 4*idx] in CMP; in IDLE and FIN they SHALL be driven with 4'b0000.
REQ-021 In CMP, cmp_agb=1: set agb=1, go to FIN (early termination, MSB-first).
REQ-022 In CMP, cmp_agb=0 and cmp_alb=1: set alb=1, go to FIN.
REQ-023 In CMP, cmp_agb=0, cmp_alb=0, idx=0: set eq=1, go to FIN; idx>0: decrement idx, stay in CMP.
REQ-024 Comparator inputs not one-hot SHALL be resolved by priority agb > alb > equal, per REQ-021..023.
REQ-025 FIN SHALL last exactly one cycle with done=1, then go to IDLE; done SHALL be 0 in all other states.
REQ-026 Latency, start sampled at edge k: done high in cycle k+1+m, where m = number of CMP cycles (1..NIBBLES); minimum 2 cycles, maximum NIBBLES+1.
REQ-027 eq/agb/alb SHALL be exactly one-hot from done onward and held until the next accepted start or reset.
REQ-028 start asserted in the FIN cycle SHALL be ignored; start held high SHALL be accepted in the first IDLE cycle after FIN (back-to-back operation, one idle cycle between).

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state=IDLE, idx=0, a_reg=b_reg=0, busy=0, done=0, eq=agb=alb=0, nib_a=nib_b=0.
REQ-030 Reset asserted mid-comparison (CMP or FIN) SHALL abort the operation with no done pulse and no partial result.
REQ-031 start asserted concurrently with rst_n=0 SHALL be ignored.

Verification
REQ-032 SHALL cover: NIBBLES=4, a=16'h1234, b=16'h1234 -> 4 CMP cycles, nib_a sequence 1,2,3,4; done 5 cycles after start; eq=1.
REQ-033 SHALL cover: a=16'h9000, b=16'h1FFF -> 1 CMP cycle; done 2 cycles after start; agb=1, eq=alb=0.
REQ-034 SHALL cover: a=16'h12A0, b=16'h12B0 -> 3 CMP cycles; done 4 cycles after start; alb=1.
REQ-035 SHALL cover: start held high continuously with a=b=0 -> eq pulses repeat every 6 cycles; changing a during busy has no effect on result.
REQ-036 SHALL cover: rst_n=0 during 2nd CMP cycle of a=16'hFFFF, b=16'hFFFE -> no done, all outputs 0 next cycle; new start afterward gives agb=1.
REQ-037 SHALL check with a behavioral 4-bit comparator model attached and random a, b (at least 1000 operations): results match unsigned A vs B, one-hot, latency per REQ-026.
